frame_scan_ctrl: RTL and testbench

FRAME_SCAN_CTRL -- requirements
Module: frame_scan_ctrl

---
 rtl/frame_scan_ctrl.sv | 166 ++++++++++++++++
 tb/tb_frame_scan_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scan_ctrl.sv
// Frame scan sequencer: walks lines x focal zones, firing PREP/FIRE/LISTEN/GAP
// gate windows per zone and pulsing End_Gate once per completed frame.
module frame_scan_ctrl #(
  parameter int PR_CYC   = 16,
  parameter int TX_CYC   = 8,
  parameter int RX_CYC   = 1024,
  parameter int GAP_CYC  = 32,
  parameter int LINE_MAX = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic       continuous,
  input  logic [1:0] cfg_focus_cnt,
  output logic [7:0] Line_Num,
  output logic [1:0] Focus_Num,
  output logic       Pr_Gate,
  output logic       RX_Gate,
  output logic       Envelop,
  output logic       End_Gate,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PREP   = 3'd1,
    FIRE   = 3'd2,
    LISTEN = 3'd3,
    GAP    = 3'd4,
    FEND   = 3'd5
  } state_t;

  localparam logic [15:0] PR_LOAD   = 16'(PR_CYC - 1);
  localparam logic [15:0] TX_LOAD   = 16'(TX_CYC - 1);
  localparam logic [15:0] RX_LOAD   = 16'(RX_CYC - 1);
  localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYC - 1);
  localparam logic [7:0]  LINE_LAST = 8'(LINE_MAX);

  // A zero zone count is treated as a single zone.
  function automatic logic [1:0] norm_focus(input logic [1:0] cfg);
    norm_focus = (cfg == 2'd0) ? 2'd1 : cfg;
  endfunction

  state_t      state_r, state_s;
  logic [15:0] cnt_r, cnt_s;
  logic [1:0]  focus_cnt_r, focus_cnt_s;
  logic [7:0]  line_s;
  logic [1:0]  focus_s;
  logic        abort_s;
  logic        done_s;

  // Next-state, phase counter and line/zone stepping.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    line_s      = Line_Num;
    focus_s     = Focus_Num;
    focus_cnt_s = focus_cnt_r;
    abort_s     = stop && (state_r != IDLE);
    done_s      = (cnt_r == 16'd0);
    if (abort_s) begin
      state_s = IDLE;
      cnt_s   = 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && !stop) begin
            state_s     = PREP;
            cnt_s       = PR_LOAD;
            line_s      = 8'd0;
            focus_s     = 2'd0;
            focus_cnt_s = norm_focus(cfg_focus_cnt);
          end else begin
            cnt_s = 16'd0;
          end
        end
        PREP: begin
          if (done_s) begin
            state_s = FIRE;
            cnt_s   = TX_LOAD;
          end else begin
            cnt_s = cnt_r - 16'd1;
          end
        end
        FIRE: begin
          if (done_s) begin
            state_s = LISTEN;
            cnt_s   = RX_LOAD;
          end else begin
            cnt_s = cnt_r - 16'd1;
          end
        end
        LISTEN: begin
          if (done_s) begin
            state_s = GAP;
            cnt_s   = GAP_LOAD;
          end else begin
            cnt_s = cnt_r - 16'd1;
          end
        end
        GAP: begin
          if (!done_s) begin
            cnt_s = cnt_r - 16'd1;
          end else if (Focus_Num < (focus_cnt_r - 2'd1)) begin
            state_s = PREP;
            cnt_s   = PR_LOAD;
            focus_s = Focus_Num + 2'd1;
          end else if (Line_Num < LINE_LAST) begin
            state_s = PREP;
            cnt_s   = PR_LOAD;
            focus_s = 2'd0;
            line_s  = Line_Num + 8'd1;
          end else begin
            state_s = FEND;
            cnt_s   = 16'd0;
          end
        end
        FEND: begin
          if (continuous) begin
            state_s     = PREP;
            cnt_s       = PR_LOAD;
            line_s      = 8'd0;
            focus_s     = 2'd0;
            focus_cnt_s = norm_focus(cfg_focus_cnt);
          end else begin
            state_s = IDLE;
            cnt_s   = 16'd0;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = 16'd0;
        end
      endcase
    end
  end

  // State, counters and registered gate decode of the upcoming state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= 16'd0;
      focus_cnt_r <= 2'd1;
      Line_Num    <= 8'd0;
      Focus_Num   <= 2'd0;
      Pr_Gate     <= 1'b0;
      RX_Gate     <= 1'b0;
      Envelop     <= 1'b0;
      End_Gate    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      focus_cnt_r <= focus_cnt_s;
      Line_Num    <= line_s;
      Focus_Num   <= focus_s;
      Pr_Gate     <= (state_s == PREP);
      RX_Gate     <= (state_s == FIRE);
      Envelop     <= (state_s == LISTEN);
      End_Gate    <= (state_s == FEND);
      busy        <= (state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_frame_scan_ctrl.sv
// Scoreboard bench for frame_scan_ctrl: stimulus pushes the expected per-cycle
// output pattern, a negedge monitor pops and compares while the DUT is active.
module tb_frame_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       stop;
  logic       continuous;
  logic [1:0] cfg_focus_cnt;
  logic [7:0] Line_Num;
  logic [1:0] Focus_Num;
  logic       Pr_Gate, RX_Gate, Envelop, End_Gate, busy;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  gates;
    logic        bsy;
    logic [7:0]  line;
    logic [1:0]  focus;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   vecs  = 0;
  int   fails = 0;
  int   base;

  frame_scan_ctrl #(
    .PR_CYC(2), .TX_CYC(1), .RX_CYC(3), .GAP_CYC(1), .LINE_MAX(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .continuous(continuous), .cfg_focus_cnt(cfg_focus_cnt),
    .Line_Num(Line_Num), .Focus_Num(Focus_Num), .Pr_Gate(Pr_Gate),
    .RX_Gate(RX_Gate), .Envelop(Envelop), .End_Gate(End_Gate), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected cycle k of a frame (k=1 is the cycle after start is accepted).
  task automatic push_frame(input int b, input logic [1:0] cnt, input int limit);
    int   k;
    int   n;
    exp_t e;
    k = 0;
    n = (cnt == 2'd0) ? 1 : int'(cnt);
    for (int l = 0; l < 3; l++) begin
      for (int f = 0; f < n; f++) begin
        for (int p = 0; p < 7; p++) begin
          k++;
          e.cyc   = 32'(b + k);
          e.gates = (p < 2) ? 4'b1000 : (p == 2) ? 4'b0100 : (p < 6) ? 4'b0010 : 4'b0000;
          e.bsy   = 1'b1;
          e.line  = 8'(l);
          e.focus = 2'(f);
          if (k <= limit) sb.push_back(e);
        end
      end
    end
    k++;
    e.cyc   = 32'(b + k);
    e.gates = 4'b0001;
    e.bsy   = 1'b1;
    e.line  = 8'd2;
    e.focus = 2'(n - 1);
    if (k <= limit) sb.push_back(e);
  endtask

  // Caller is at a negedge; start is sampled on the next rising edge.
  task automatic issue_start(input logic [1:0] cnt, input logic cont, input int limit,
                             output int b);
    cfg_focus_cnt = cnt;
    continuous    = cont;
    start         = 1'b1;
    b             = cyc;
    push_frame(b, cnt, limit);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 2000 && cyc != target; i++) @(negedge clk);
    if (cyc != target) begin
      vecs++;
      fails++;
      $display("FAIL wait_cyc: got cycle %0d, expected %0d", cyc, target);
    end
  endtask

  task automatic wait_drain(input int bound);
    int done;
    done = 0;
    for (int i = 0; i < bound && done == 0; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) done = 1;
    end
    vecs++;
    if (done == 0) begin
      fails++;
      $display("FAIL drain: got %0d pending items busy=%b, expected 0 and idle", sb.size(), busy);
      sb.delete();
    end
  endtask

  task automatic chk_idle(input string name, input logic [7:0] line, input logic [1:0] focus);
    chk({name, "_gates"}, 32'({Pr_Gate, RX_Gate, Envelop, End_Gate, busy}), 32'd0);
    chk({name, "_line"}, 32'(Line_Num), 32'(line));
    chk({name, "_focus"}, 32'(Focus_Num), 32'(focus));
  endtask

  // Monitor: every active output cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t a;
    exp_t e;
    if (reset_n && (busy || Pr_Gate || RX_Gate || Envelop || End_Gate)) begin
      a.cyc   = 32'(cyc);
      a.gates = {Pr_Gate, RX_Gate, Envelop, End_Gate};
      a.bsy   = busy;
      a.line  = Line_Num;
      a.focus = Focus_Num;
      vecs++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got cyc=%0d gates=%b line=%0d focus=%0d, expected idle",
                 a.cyc, a.gates, a.line, a.focus);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          fails++;
          $display("FAIL scoreboard: got cyc=%0d gates=%b busy=%b line=%0d focus=%0d, expected cyc=%0d gates=%b busy=%b line=%0d focus=%0d",
                   a.cyc, a.gates, a.bsy, a.line, a.focus, e.cyc, e.gates, e.bsy, e.line, e.focus);
        end
      end
    end
  end

  initial begin
    reset_n       = 1'b0;
    start         = 1'b0;
    stop          = 1'b0;
    continuous    = 1'b0;
    cfg_focus_cnt = 2'd0;
    #12;
    chk_idle("reset", 8'd0, 2'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Two zones, single frame: End_Gate on cycle 43.
    @(negedge clk);
    issue_start(2'd2, 1'b0, 1000, base);
    wait_drain(100);
    chk_idle("frame2_end", 8'd2, 2'd1);

    // Zero zone count behaves as one zone: 21 firing cycles then FEND.
    @(negedge clk);
    issue_start(2'd0, 1'b0, 1000, base);
    wait_drain(100);
    chk_idle("frame0_end", 8'd2, 2'd0);

    // Stop in the second LISTEN cycle of (1,0).
    @(negedge clk);
    issue_start(2'd2, 1'b0, 19, base);
    wait_cyc(base + 19);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk_idle("stop_abort", 8'd1, 2'd0);
    wait_drain(20);

    // Continuous: zone count changes mid-frame, takes effect on the next frame.
    @(negedge clk);
    issue_start(2'd1, 1'b1, 1000, base);
    push_frame(base + 22, 2'd3, 1000);
    wait_cyc(base + 5);
    cfg_focus_cnt = 2'd3;
    wait_cyc(base + 30);
    continuous = 1'b0;
    wait_drain(200);
    chk_idle("cont_end", 8'd2, 2'd2);

    // start and stop together in IDLE: nothing happens.
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk_idle("start_stop_idle", 8'd2, 2'd2);

    // start pulsed during FIRE is ignored.
    @(negedge clk);
    issue_start(2'd1, 1'b0, 1000, base);
    wait_cyc(base + 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain(100);

    // Asynchronous reset mid-GAP of (0,1), then a start on the first edge after release.
    @(negedge clk);
    issue_start(2'd2, 1'b0, 14, base);
    wait_cyc(base + 14);
    #1;
    reset_n = 1'b0;
    #1;
    chk_idle("async_reset", 8'd0, 2'd0);
    @(negedge clk);
    reset_n = 1'b1;
    issue_start(2'd2, 1'b0, 1000, base);
    wait_drain(100);
    chk_idle("after_reset_end", 8'd2, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
